// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a 16-deep show-ahead FIFO in bursts of up to
// BURST_LEN beats onto a valid/ready stream with an end-of-burst marker.
// Popped words pass through a hold register (H) into the output register (O).
// Optional statistics counters: define FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_threshold,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  input  logic                  flush,
  output logic                  busy,
  output logic                  flush_done
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_partial,
  output logic [15:0]           stat_stall
`endif
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BL    = BW'(BURST_LEN);
  localparam logic [BW-1:0] BLM1  = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] ONE   = BW'(1);
  localparam logic [7:0]    TO_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            flush_pend_q, flush_pend_d;
  logic            flush_done_q, flush_done_d;

  logic                  h_valid_q, h_last_q;
  logic [DATA_WIDTH-1:0] h_data_q;
  logic                  o_valid_q, o_last_q;
  logic [DATA_WIDTH-1:0] o_data_q;

  logic h_move, pop, xfer, pend;

  assign h_move = h_valid_q & (~o_valid_q | m_ready);
  assign pop    = ~rst & (state_q == BURST) & ~fifo_empty & (beats_q < BL) &
                  (~h_valid_q | h_move);
  assign xfer   = o_valid_q & m_ready;
  assign pend   = flush_pend_q | flush;

  assign fifo_rd    = pop;
  assign m_data     = o_data_q;
  assign m_valid    = o_valid_q;
  assign m_last     = o_last_q;
  assign busy       = (state_q != IDLE);
  assign flush_done = flush_done_q;

  // Next-state logic for the burst FSM, counters and flush bookkeeping.
  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    tmo_d        = tmo_q;
    flush_pend_d = pend;
    flush_done_d = 1'b0;
    if (pop) beats_d = beats_q + ONE;
    case (state_q)
      IDLE: begin
        tmo_d = fifo_empty ? '0 : tmo_q + 8'd1;
        if (fifo_empty && pend) begin
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
        end else if (!fifo_empty && (fifo_threshold || pend || tmo_q >= TO_M1)) begin
          state_d = BURST;
        end
      end
      BURST: begin
        // The empty-exit also fires in the cycle H moves out flagged last, so a
        // word written right after that move cannot extend a burst past m_last.
        if (pop && beats_q == BLM1) begin
          state_d = DRAIN;
        end else if (fifo_empty && beats_q != '0 && (!h_valid_q || h_move)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && o_last_q) begin
          state_d = IDLE;
          beats_d = '0;
          tmo_d   = '0;
          if (pend && fifo_empty) begin
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beats_q      <= '0;
      tmo_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      tmo_q        <= tmo_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Hold and output pipeline registers; O stays frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_q <= 1'b0;
      h_last_q  <= 1'b0;
      h_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      if (h_move) begin
        o_valid_q <= 1'b1;
        o_data_q  <= h_data_q;
        o_last_q  <= h_last_q | fifo_empty;
      end else if (xfer) begin
        o_valid_q <= 1'b0;
      end
      if (pop) begin
        h_valid_q <= 1'b1;
        h_data_q  <= fifo_data;
        h_last_q  <= (beats_q == BLM1);
      end else if (h_move) begin
        h_valid_q <= 1'b0;
      end
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] stat_bursts_q, stat_partial_q, stat_stall_q;

  assign stat_bursts  = stat_bursts_q;
  assign stat_partial = stat_partial_q;
  assign stat_stall   = stat_stall_q;

  // Saturating burst, partial-burst and stall-cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts_q  <= '0;
      stat_partial_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      if (xfer && o_last_q && stat_bursts_q != '1)
        stat_bursts_q <= stat_bursts_q + 16'd1;
      if (xfer && o_last_q && beats_q < BL && stat_partial_q != '1)
        stat_partial_q <= stat_partial_q + 16'd1;
      if (o_valid_q && !m_ready && stat_stall_q != '1)
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural 16-deep show-ahead FIFO feeds the
// DUT; expected beats go into a scoreboard queue, a monitor pops and compares.
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, fifo_empty, fifo_threshold, fifo_rd;
  logic       m_valid, m_ready, m_last, flush, busy, flush_done;
  logic [7:0] fifo_data, m_data;

  fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_threshold(fifo_threshold), .fifo_rd(fifo_rd), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .flush(flush),
    .busy(busy), .flush_done(flush_done)
  );

  // Behavioural show-ahead FIFO.
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  logic       wr_en, fifo_clr, underflow;
  logic [7:0] wr_data;

  assign fifo_data      = mem[rp];
  assign fifo_empty     = (cnt == 5'd0);
  assign fifo_threshold = (cnt >= 5'd8);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0; underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd === 1'b1) begin
        rp <= rp + 4'd1;
        if (cnt == 5'd0) underflow <= 1'b1;
      end
      cnt <= cnt + {4'd0, wr_en} - {4'd0, (fifo_rd === 1'b1)};
    end
  end

  // Event bookkeeping: pops, flush_done pulses, cycle of the last m_last transfer.
  int unsigned rd_cnt = 0, fd_cnt = 0, fd_cyc = 0, lx_cyc = 0, cyc = 0;
  always @(posedge clk) if (fifo_rd === 1'b1) rd_cnt <= rd_cnt + 1;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (flush_done === 1'b1) begin fd_cnt <= fd_cnt + 1; fd_cyc <= cyc; end
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1 && m_last === 1'b1) lx_cyc <= cyc;
  end

  int unsigned n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  beat_t exp_q[$];

  task automatic expect_beat(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    exp_q.push_back(b);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  initial forever begin
    beat_t b;
    @(negedge clk);
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", m_data, m_last);
      end else begin
        b = exp_q.pop_front();
        check("beat_data", 32'(m_data), 32'(b.d));
        check("beat_last", 32'(m_last), 32'(b.l));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin tick(); n++; end
    check(name, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int unsigned n = 0;
    while (m_valid !== 1'b1 && n < 30) begin tick(); n++; end
    check(name, 32'(m_valid), 32'd1);
  endtask

  initial begin
    int unsigned n, base_rd, base_fd;
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'd0; fifo_clr = 1'b1;
    repeat (3) tick();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    check("rst_fifo_rd", 32'(fifo_rd), 0);
    rst = 1'b0; fifo_clr = 1'b0;
    tick();

    // T1: 8 words, threshold start, two 4-beat bursts.
    m_ready = 1'b1;
    base_rd = rd_cnt;
    for (int i = 0; i < 8; i++) begin
      expect_beat(8'(8'h10 + i), (i == 3 || i == 7));
      write_word(8'(8'h10 + i));
    end
    n = 0;
    while (fifo_rd !== 1'b1 && n < 50) begin tick(); n++; end
    check("t1_rd_seen", 32'(fifo_rd), 1);
    tick();
    check("t1_lat1_m_valid", 32'(m_valid), 0);
    tick();
    check("t1_lat2_m_valid", 32'(m_valid), 1);
    check("t1_lat2_m_data", 32'(m_data), 32'h10);
    wait_drained("t1_drained");
    check("t1_rd_count", rd_cnt - base_rd, 8);
    check("t1_fifo_empty", 32'(fifo_empty), 1);

    // T2: 3 words, timeout start. Writes end in nonempty cycle 3; the
    // counter hits 15 at the end of cycle 15, so fifo_rd first rises in cycle 16.
    base_rd = rd_cnt;
    expect_beat(8'hA0, 1'b0); expect_beat(8'hA1, 1'b0); expect_beat(8'hA2, 1'b1);
    write_word(8'hA0); write_word(8'hA1); write_word(8'hA2);
    n = 0;
    while (fifo_rd !== 1'b1 && n < 40) begin tick(); n++; end
    check("t2_timeout_cycles", n, 13);
    wait_drained("t2_drained");
    check("t2_rd_count", rd_cnt - base_rd, 3);
    check("t2_busy", 32'(busy), 0);

    // T3: 5 words plus flush: bursts of 4 and 1, one flush_done after final beat.
    base_fd = fd_cnt;
    for (int i = 0; i < 5; i++) begin
      expect_beat(8'(8'hB0 + i), (i == 3 || i == 4));
      write_word(8'(8'hB0 + i));
    end
    pulse_flush();
    wait_drained("t3_drained");
    tick(); tick();
    check("t3_flush_done_count", fd_cnt - base_fd, 1);
    check("t3_flush_done_delay", fd_cyc - lx_cyc, 1);

    // T4: stall with m_ready low; O frozen, popping stops once H is full.
    m_ready = 1'b0;
    base_rd = rd_cnt;
    for (int i = 0; i < 4; i++) begin
      expect_beat(8'(8'hC0 + i), (i == 3));
      write_word(8'(8'hC0 + i));
    end
    pulse_flush();
    wait_valid("t4_m_valid_seen");
    check("t4_pops_before_stall", rd_cnt - base_rd, 2);
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_valid", 32'(m_valid), 1);
      check("t4_stall_data", 32'(m_data), 32'hC0);
      check("t4_stall_last", 32'(m_last), 0);
      check("t4_stall_rd", 32'(fifo_rd), 0);
      tick();
    end
    m_ready = 1'b1;
    wait_drained("t4_drained");
    check("t4_rd_count", rd_cnt - base_rd, 4);
    tick(); tick();

    // T5: reset mid-burst; D0/D1 are discarded, D2 stays at the FIFO head.
    base_rd = rd_cnt;
    base_fd = fd_cnt;
    expect_beat(8'hD2, 1'b0); expect_beat(8'hD3, 1'b1);
    for (int i = 0; i < 4; i++) write_word(8'(8'hD0 + i));
    pulse_flush();
    wait_valid("t5_m_valid_seen");
    check("t5_rd_before_rst", 32'(fifo_rd), 1);
    rst = 1'b1;
    #1;
    check("t5_rd_in_rst", 32'(fifo_rd), 0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_after_rst_m_valid", 32'(m_valid), 0);
    check("t5_after_rst_busy", 32'(busy), 0);
    check("t5_after_rst_fifo_rd", 32'(fifo_rd), 0);
    wait_drained("t5_drained");
    check("t5_rd_count", rd_cnt - base_rd, 4);
    tick(); tick();
    check("t5_no_flush_done", fd_cnt - base_fd, 0);

    // T6: flush on an empty FIFO.
    base_rd = rd_cnt;
    pulse_flush();
    check("t6_flush_done", 32'(flush_done), 1);
    check("t6_busy", 32'(busy), 0);
    tick();
    check("t6_flush_done_clear", 32'(flush_done), 0);
    check("t6_m_valid", 32'(m_valid), 0);
    check("t6_rd_count", rd_cnt - base_rd, 0);

    tick();
    check("fifo_underflow", 32'(underflow), 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
